// File: rtl/sha256_arbiter.sv
// Shares one SHA-256 core among NUM_REQ block-streaming requesters: whole-message
// round-robin grants, init/next sequencing, tagged digest return and stall abort.
module sha256_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ*512-1:0] req_block_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic [255:0]           rsp_digest_o,
    output logic                   abort_o,
    output logic [ID_W-1:0]        abort_id_o,
    output logic                   busy_o,
    output logic                   core_init_o,
    output logic                   core_next_o,
    output logic [511:0]           core_block_o,
    input  logic [255:0]           core_digest_i,
    input  logic                   core_ready_i
);

    localparam int unsigned BLK_W   = 512;
    localparam int unsigned DIG_W   = 256;
    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_GUARD, S_WAIT, S_NEXT, S_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, owner_q, abort_id_q;
    logic [BLK_W-1:0]   block_q;
    logic [DIG_W-1:0]   digest_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_q, first_q, abort_q;

    logic               win_found;
    logic [ID_W-1:0]    win_id, rr_id, sel_id, owner_inc;
    logic [BLK_W-1:0]   sel_block;
    logic               timeout_hit;

    // Round-robin search starting at the pointer
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        rr_id     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            rr_id = ID_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!win_found && req_valid_i[rr_id]) begin
                win_found = 1'b1;
                win_id    = rr_id;
            end
        end
    end

    assign sel_id      = (state_q == S_IDLE) ? win_id : owner_q;
    assign sel_block   = req_block_i[32'(sel_id)*BLK_W +: BLK_W];
    assign owner_inc   = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST));

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (core_ready_i && win_found) state_d = S_ISSUE;
            S_ISSUE: state_d = S_GUARD;
            S_GUARD: state_d = S_WAIT;
            S_WAIT:  if (core_ready_i) state_d = last_q ? S_RESP : S_NEXT;
            S_NEXT: begin
                if (req_valid_i[owner_q]) state_d = S_ISSUE;
                else if (timeout_hit)     state_d = S_IDLE;
            end
            S_RESP:  if (rsp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs; ready stays combinational so grants land in the same cycle
    always_comb begin
        req_ready_o = '0;
        core_init_o = 1'b0;
        core_next_o = 1'b0;
        rsp_valid_o = 1'b0;
        busy_o      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:  if (core_ready_i && win_found) req_ready_o[win_id] = 1'b1;
            S_ISSUE: begin
                core_init_o = first_q;
                core_next_o = !first_q;
            end
            S_NEXT:  req_ready_o[owner_q] = req_valid_i[owner_q];
            S_RESP:  rsp_valid_o = 1'b1;
            default: ;
        endcase
    end

    // Block, digest, ownership and timeout bookkeeping
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            owner_q    <= '0;
            abort_id_q <= '0;
            block_q    <= '0;
            digest_q   <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            first_q    <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (core_ready_i && win_found) begin
                        owner_q <= win_id;
                        block_q <= sel_block;
                        last_q  <= req_last_i[win_id];
                        first_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (core_ready_i) begin
                        if (last_q) begin
                            digest_q <= core_digest_i;
                        end else begin
                            first_q <= 1'b0;
                            cnt_q   <= '0;
                        end
                    end
                end
                S_NEXT: begin
                    if (req_valid_i[owner_q]) begin
                        block_q <= sel_block;
                        last_q  <= req_last_i[owner_q];
                    end else if (timeout_hit) begin
                        abort_q    <= 1'b1;
                        abort_id_q <= owner_q;
                        ptr_q      <= owner_inc;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RESP: if (rsp_ready_i) ptr_q <= owner_inc;
                default: ;
            endcase
        end
    end

    assign core_block_o = block_q;
    assign rsp_id_o     = owner_q;
    assign rsp_digest_o = digest_q;
    assign abort_o      = abort_q;
    assign abort_id_o   = abort_id_q;

endmodule
